// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one shared MAC sweeps all taps per accepted sample, with a
// double-buffered coefficient bank. Optional FIR_MAC_SAT_EN clamps dout instead of wrapping.
module fir_mac_seq #(
  parameter int DIN_W  = 10,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int DOUT_W = 11,
  parameter int SHIFT  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIN_W-1:0]         din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DOUT_W-1:0]        dout,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     coef_commit,
  output logic                     busy
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DIN_W + COEF_W;
  localparam int ACC_W = DIN_W + COEF_W + $clog2(TAPS);
  localparam int TOP   = SHIFT + DOUT_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;
  state_t r_state, w_state_nxt;

  logic signed [DIN_W-1:0]  r_tap    [TAPS];
  logic signed [COEF_W-1:0] r_shadow [TAPS];
  logic signed [COEF_W-1:0] r_active [TAPS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [AW-1:0]            r_idx;
  logic [DOUT_W-1:0]        r_dout;
  logic                     r_commit_pend;

  logic                     w_accept, w_last, w_release, w_do_commit, w_addr_ok;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [DOUT_W-1:0]        w_dout_nxt;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_last      = (r_state == S_ACCUM) && (r_idx == AW'(TAPS-1));
  assign w_release   = (r_state == S_HOLD) && out_ready;
  // A commit seen while busy waits for the return to IDLE so one result never mixes banks.
  assign w_do_commit = ((r_state == S_IDLE) && coef_commit) ||
                       (w_release && (r_commit_pend || coef_commit));
  assign w_addr_ok   = {1'b0, coef_addr} < (AW+1)'(TAPS);

  assign w_prod    = r_tap[r_idx] * r_active[r_idx];
  assign w_acc_nxt = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  always_comb begin
    w_dout_nxt = w_acc_nxt[TOP:SHIFT];
`ifdef FIR_MAC_SAT_EN
    if (!((&w_acc_nxt[ACC_W-1:TOP]) || !(|w_acc_nxt[ACC_W-1:TOP])))
      w_dout_nxt = w_acc_nxt[ACC_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}}
                                      : {1'b0, {(DOUT_W-1){1'b1}}};
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        r_tap[k]    <= '0;
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_acc         <= '0;
      r_idx         <= '0;
      r_dout        <= '0;
      r_commit_pend <= 1'b0;
    end else begin
      if (coef_we && w_addr_ok) r_shadow[coef_addr] <= coef_data;
      if (w_do_commit)
        for (int k = 0; k < TAPS; k++) r_active[k] <= r_shadow[k];
      if (w_release)                      r_commit_pend <= 1'b0;
      else if (busy && coef_commit)       r_commit_pend <= 1'b1;

      if (w_accept) begin
        r_tap[0] <= din;
        for (int k = 1; k < TAPS; k++) r_tap[k] <= r_tap[k-1];
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == S_ACCUM) begin
        r_acc <= w_acc_nxt;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_dout <= w_dout_nxt;
      end
    end
  end

  assign dout = r_dout;
endmodule
